serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 155 +++++++++++++++
 tb/tb_serial_adder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit unsigned operands LSB-first, one bit
// per clock, through a single full-add cell and a registered carry.
//
// Handshake: start is sampled only while busy=0 (IDLE or DONE). The accepting
// edge captures a/b and raises busy; WIDTH SHIFT steps follow, each emitting
// one s_bit with s_valid=1. The last step lowers busy, pulses done for one
// cycle and updates sum/cout, which then hold until the next result.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             s_bit,
  output logic             s_valid,
  output logic [1:0]       state_dbg
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   ra_q, ra_d;
  logic [WIDTH-1:0]   rb_q, rb_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               c_q, c_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               s_bit_q, s_bit_d;
  logic               s_valid_q, s_valid_d;

  // Full-add cell on the current LSBs and the registered carry.
  logic             s_w;
  logic             c_w;
  logic [WIDTH-1:0] res_shift;

  assign s_w = ra_q[0] ^ rb_q[0] ^ c_q;
  assign c_w = (ra_q[0] & rb_q[0]) | (c_q & (ra_q[0] ^ rb_q[0]));

  // New sum bit enters at the MSB so the first (LSB) bit reaches bit 0
  // after WIDTH steps.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_shift = s_w;
    end else begin : g_res_wn
      assign res_shift = {s_w, res_q[WIDTH-1:1]};
    end
  endgenerate

  // State and datapath registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ra_q      <= '0;
      rb_q      <= '0;
      res_q     <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      c_q       <= 1'b0;
      cout_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      s_bit_q   <= 1'b0;
      s_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      res_q     <= res_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      c_q       <= c_d;
      cout_q    <= cout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      s_bit_q   <= s_bit_d;
      s_valid_q <= s_valid_d;
    end
  end

  // Next-state and datapath updates; DONE accepts start just like IDLE.
  always_comb begin
    state_d   = state_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    res_d     = res_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    c_d       = c_q;
    cout_d    = cout_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    s_bit_d   = s_bit_q;
    s_valid_d = s_valid_q;

    unique case (state_q)
      IDLE, DONE: begin
        state_d   = IDLE;
        busy_d    = 1'b0;
        s_valid_d = 1'b0;
        if (start) begin
          state_d = SHIFT;
          ra_d    = a;
          rb_d    = b;
          c_d     = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      SHIFT: begin
        ra_d      = ra_q >> 1;
        rb_d      = rb_q >> 1;
        c_d       = c_w;
        res_d     = res_shift;
        s_bit_d   = s_w;
        s_valid_d = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          sum_d   = res_shift;
          cout_d  = c_w;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign s_bit     = s_bit_q;
  assign s_valid   = s_valid_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder (WIDTH=8). Directed operations push hand-computed
// results into expected queues; an independent monitor pops and compares
// whenever the DUT presents s_valid or done.
module tb_serial_adder;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout, s_bit, s_valid;
  logic [W-1:0] sum;
  logic [1:0]   state_dbg;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .s_bit     (s_bit),
    .s_valid   (s_valid),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [W:0] exp_q[$];     // {cout, sum}
  logic [0:0] bit_q[$];     // serial bits, LSB first
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] s, input logic c);
    exp_q.push_back({c, s});
    for (int i = 0; i < W; i++) bit_q.push_back(s[i]);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W:0] e;
    logic [0:0] eb;
    if (done && busy) chk("done_busy_overlap", 32'(done & busy), 32'd0);
    if (s_valid) begin
      if (bit_q.size() == 0) chk("s_bit_unexpected", 32'(s_valid), 32'd0);
      else begin
        eb = bit_q.pop_front();
        chk("s_bit", 32'(s_bit), 32'(eb));
      end
    end
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) chk("done_unexpected", 32'(done), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("sum", 32'(sum), 32'(e[W-1:0]));
        chk("cout", 32'(cout), 32'(e[W]));
      end
    end
  end

  // ---------------- driver ----------------
  // Issue one operation and check done arrives exactly W cycles after
  // the accepting edge.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] es, input logic ec);
    int j;
    bit seen;
    push_exp(es, ec);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);           // accepting edge has passed
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    j = 0; seen = 0;
    while (!seen && j < 40) begin
      @(negedge clk);
      j++;
      if (done) seen = 1;
    end
    chk("done_latency", 32'(j), 32'(W));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dc;
    int j;
    int nd;
    int t[3];

    // Reset then idle.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_svalid", 32'(s_valid), 32'd0);
      chk("idle_sum", 32'(sum), 32'd0);
      chk("idle_cout", 32'(cout), 32'd0);
    end
    chk("idle_state", 32'(state_dbg), 32'd0);

    // Basic and carry cases.
    do_op(8'hA5, 8'h5A, 8'hFF, 1'b0);
    do_op(8'hFF, 8'h01, 8'h00, 1'b1);
    do_op(8'h80, 8'h80, 8'h00, 1'b1);
    do_op(8'hC3, 8'h7E, 8'h41, 1'b1);
    // Result holds between operations.
    repeat (3) @(negedge clk);
    chk("hold_sum", 32'(sum), 32'h41);
    chk("hold_cout", 32'(cout), 32'd1);

    // Ignored start while busy.
    dc = done_cnt;
    push_exp(8'h07, 1'b0);
    @(negedge clk);
    a = 8'h03; b = 8'h04; start = 1'b1;
    @(negedge clk);
    a = 8'hFF; b = 8'hFF;       // start stays high, must be ignored
    repeat (4) @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);
    chk("ignored_start_dones", 32'(done_cnt - dc), 32'd1);

    // Back-to-back with start held high.
    for (int i = 0; i < 3; i++) push_exp(8'h30, 1'b0);
    @(negedge clk);
    a = 8'h10; b = 8'h20; start = 1'b1;
    @(negedge clk);
    j = 0; nd = 0;
    while (nd < 3 && j < 60) begin
      chk("b2b_busy", 32'(busy), 32'(!done));
      @(negedge clk);
      j++;
      if (done) begin
        t[nd] = j;
        nd++;
      end
    end
    start = 1'b0;
    chk("b2b_count", 32'(nd), 32'd3);
    chk("b2b_first", 32'(t[0]), 32'd8);
    chk("b2b_gap1", 32'(t[1] - t[0]), 32'd9);
    chk("b2b_gap2", 32'(t[2] - t[1]), 32'd9);
    repeat (3) @(negedge clk);

    // Reset mid-operation: 0x55+0x55 = 0xAA, first four bits 0,1,0,1.
    bit_q.push_back(1'b0); bit_q.push_back(1'b1);
    bit_q.push_back(1'b0); bit_q.push_back(1'b1);
    dc = done_cnt;
    a = 8'h55; b = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_svalid", 32'(s_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("rst_no_done", 32'(done_cnt - dc), 32'd0);
    do_op(8'h01, 8'h01, 8'h02, 1'b0);

    repeat (4) @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("bit_q_drained", 32'(bit_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
